// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_pkg
//  Purpose  : Shared definitions for the PE dot-product controller:
//             controller state encoding, Q24.8 fixed-point constants and a
//             saturating 32-bit increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

   // Controller states, explicitly encoded.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READ  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } pe_state_t;

   // Q24.8 operand format; the PE adds only the low CIN_BITS of pe_cin.
   localparam int FRAC_BITS = 8;
   localparam int CIN_BITS  = 24;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pe_ctrl
//  Purpose  : Dot-product sequencer for a single multiply-accumulate PE with
//             a local RAM. Loads the B vector into the PE RAM, then for each
//             element reads B, issues A together with the running sum, waits
//             a fixed PE_LAT cycles and captures the PE result as the new sum.
//  Ports    : aclk/aresetn      - clock, async active-low reset
//             start/len         - job request and vector length (0..2**L)
//             b_*               - B-vector valid/ready stream (LOAD only)
//             a_*               - A-vector valid/ready stream (ISSUE only)
//             pe_*              - PE operand, RAM and result interface
//             result/_valid     - final dot product, one-cycle pulse
//             busy              - high whenever the controller is not idle
//             cyc_cnt           - busy cycles of last job (optional)
//  Options  : define PE_CTRL_CYCCNT_EN to add the cyc_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_ctrl
   import pe_pkg::*;
#(
   parameter int L_RAM_SIZE = 6,
   parameter int PE_LAT     = 4
)
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [L_RAM_SIZE:0]   len,
   input  logic [31:0]           b_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [31:0]           a_data,
   input  logic                  a_valid,
   output logic                  a_ready,
   output logic [31:0]           pe_ain,
   output logic [31:0]           pe_din,
   output logic [31:0]           pe_cin,
   output logic [L_RAM_SIZE-1:0] pe_addr,
   output logic                  pe_we,
   output logic                  pe_valid,
   input  logic [31:0]           pe_dout,
   output logic [31:0]           result,
   output logic                  result_valid,
`ifdef PE_CTRL_CYCCNT_EN
   output logic [31:0]           cyc_cnt,
`endif
   output logic                  busy
);

   // Wait counter only needs to reach PE_LAT-1.
   localparam int WCW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

   pe_state_t             r_state;
   pe_state_t             w_next;
   logic [L_RAM_SIZE:0]   r_i;       // one bit wider than the address so len=2**L terminates
   logic [L_RAM_SIZE:0]   r_len;     // len captured at start; the port may change mid-job
   logic [L_RAM_SIZE:0]   w_i_inc;
   logic [31:0]           r_acc;
   logic [WCW-1:0]        r_wcnt;
   logic                  w_b_xfer;
   logic                  w_a_xfer;
   logic                  w_wait_done;

   assign w_b_xfer    = b_valid && b_ready;
   assign w_a_xfer    = a_valid && a_ready;
   assign w_i_inc     = r_i + (L_RAM_SIZE+1)'(1);
   assign w_wait_done = (r_state == ST_WAIT) && (r_wcnt == WCW'(PE_LAT-1));

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and stream handshakes
   // ------------------------------------------------------------------------
   always_comb begin
      w_next  = r_state;
      b_ready = 1'b0;
      a_ready = 1'b0;
      busy    = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            // Once all len words are accepted, one more LOAD cycle remains
            // in which the last registered write reaches the RAM.
            b_ready = (r_i != r_len);
            if (r_i == r_len) begin
               w_next = ST_READ;
            end
         end
         ST_READ: begin
            w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            a_ready = 1'b1;
            if (w_a_xfer) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Completion is timed, not flagged: a zero PE result is legal.
            if (w_wait_done) begin
               w_next = (w_i_inc == r_len) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: index, accumulator and registered PE/result outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_i          <= '0;
         r_len        <= '0;
         r_acc        <= '0;
         r_wcnt       <= '0;
         pe_ain       <= '0;
         pe_din       <= '0;
         pe_cin       <= '0;
         pe_addr      <= '0;
         pe_we        <= 1'b0;
         pe_valid     <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         pe_we        <= 1'b0;
         pe_valid     <= 1'b0;
         result_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_i   <= '0;
                  r_acc <= '0;
                  r_len <= len;
               end
            end
            ST_LOAD: begin
               if (w_b_xfer) begin
                  pe_we   <= 1'b1;
                  pe_din  <= b_data;
                  pe_addr <= r_i[L_RAM_SIZE-1:0];
                  r_i     <= w_i_inc;
               end else if (r_i == r_len) begin
                  // Rewind for the compute pass; the address presented in
                  // READ starts the RAM read of element 0.
                  r_i     <= '0;
                  pe_addr <= '0;
               end
            end
            ST_ISSUE: begin
               if (w_a_xfer) begin
                  pe_ain   <= a_data;
                  pe_cin   <= r_acc;
                  pe_valid <= 1'b1;
                  r_wcnt   <= '0;
               end
            end
            ST_WAIT: begin
               if (w_wait_done) begin
                  r_acc   <= pe_dout;
                  r_i     <= w_i_inc;
                  // Low bits wrap to 0 when len=2**L; harmless since the
                  // terminal check uses the full-width index.
                  pe_addr <= w_i_inc[L_RAM_SIZE-1:0];
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            ST_DONE: begin
               result       <= r_acc;
               result_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PE_CTRL_CYCCNT_EN
   // ------------------------------------------------------------------------
   // Busy-cycle counter: r_cyc counts busy cycles before DONE, so the
   // published value adds the DONE cycle itself.
   // ------------------------------------------------------------------------
   logic [31:0] r_cyc;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cyc   <= '0;
         cyc_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE) begin
            r_cyc <= '0;
         end else begin
            r_cyc <= sat_inc32(r_cyc);
         end
         if (r_state == ST_DONE) begin
            cyc_cnt <= sat_inc32(r_cyc);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_ctrl
//  Purpose  : Self-checking bench for pe_ctrl with a behavioural PE (local
//             RAM + fixed-latency Q24.8 MAC) and a dot-product model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_ctrl;
   import pe_pkg::*;

   localparam int L     = 6;
   localparam int LAT   = 4;
   localparam int DEPTH = 1 << L;

   logic          aclk;
   logic          aresetn;
   logic          start;
   logic [L:0]    len;
   logic [31:0]   b_data;
   logic          b_valid;
   logic          b_ready;
   logic [31:0]   a_data;
   logic          a_valid;
   logic          a_ready;
   logic [31:0]   pe_ain;
   logic [31:0]   pe_din;
   logic [31:0]   pe_cin;
   logic [L-1:0]  pe_addr;
   logic          pe_we;
   logic          pe_valid;
   logic [31:0]   pe_dout;
   logic [31:0]   result;
   logic          result_valid;
   logic          busy;
`ifdef PE_CTRL_CYCCNT_EN
   logic [31:0]   cyc_cnt;
`endif

   pe_ctrl #(.L_RAM_SIZE(L), .PE_LAT(LAT)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .start        (start),
      .len          (len),
      .b_data       (b_data),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .a_data       (a_data),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .pe_ain       (pe_ain),
      .pe_din       (pe_din),
      .pe_cin       (pe_cin),
      .pe_addr      (pe_addr),
      .pe_we        (pe_we),
      .pe_valid     (pe_valid),
      .pe_dout      (pe_dout),
      .result       (result),
      .result_valid (result_valid),
`ifdef PE_CTRL_CYCCNT_EN
      .cyc_cnt      (cyc_cnt),
`endif
      .busy         (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // ------------------------------------------------------------------------
   // PE arithmetic: (a*b)>>8 in Q24.8 plus the sign-extended low 24 bits of c
   // ------------------------------------------------------------------------
   function automatic logic [31:0] pe_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] p;
      logic signed [31:0] ce;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      ce = $signed(c[CIN_BITS-1:0]);
      return 32'(p >>> FRAC_BITS) + 32'(ce);
   endfunction

   // Behavioural PE: registered RAM read; result valid exactly LAT cycles
   // after pe_valid (counting the pe_valid cycle), garbage otherwise.
   logic [31:0] ram  [0:DEPTH-1];
   logic [31:0] pipe [0:LAT-2];
   logic [31:0] rd;

   always @(posedge aclk) begin
      if (pe_we) ram[pe_addr] <= pe_din;
      rd <= ram[pe_addr];
      pipe[0] <= pe_valid ? pe_op(pe_ain, rd, pe_cin) : $urandom;
      for (int s = 1; s < LAT-1; s++) pipe[s] <= pipe[s-1];
   end
   assign pe_dout = pipe[LAT-2];

   // ------------------------------------------------------------------------
   // Job description and dot-product model
   // ------------------------------------------------------------------------
   logic [31:0] jb   [0:DEPTH-1];
   logic [31:0] ja   [0:DEPTH-1];
   logic [31:0] psum [0:DEPTH];
   int          jlen;

   task automatic set_model(input int n);
      jlen    = n;
      psum[0] = 32'd0;
      for (int k = 0; k < n; k++) psum[k+1] = pe_op(ja[k], jb[k], psum[k]);
   endtask

   int n_vec, n_err;
   int n_we_tot, n_valid_tot, n_rv_tot;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Per-cycle compare against the model
   // ------------------------------------------------------------------------
   int          k_we, k_iss;
   logic [31:0] last_res;

   always @(negedge aclk) begin
      if (!aresetn) begin
         k_we     = 0;
         k_iss    = 0;
         last_res = 32'd0;
      end else begin
         if (pe_we) begin
            check("pe_din", pe_din, jb[pe_addr]);
            check("pe_addr_wr", 32'(pe_addr), 32'(k_we % DEPTH));
            k_we++;
            n_we_tot++;
         end
         if (pe_valid) begin
            check("pe_ain", pe_ain, ja[k_iss % DEPTH]);
            check("pe_cin", pe_cin, psum[k_iss % DEPTH]);
            check("pe_addr_rd", 32'(pe_addr), 32'(k_iss % DEPTH));
            k_iss++;
            n_valid_tot++;
         end
         if (result_valid) begin
            check("result_model", result, psum[jlen]);
            check("write_count", 32'(k_we), 32'(jlen));
            check("issue_count", 32'(k_iss), 32'(jlen));
            last_res = result;
            k_we     = 0;
            k_iss    = 0;
            n_rv_tot++;
         end else begin
            check("result_hold", result, last_res);
         end
         check("ready_overlap", {31'd0, a_ready & b_ready}, 32'd0);
      end
   end

   // ------------------------------------------------------------------------
   // Stream drivers (drive at negedge; transfer at the following posedge)
   // ------------------------------------------------------------------------
   task automatic send_b(input int n, input bit stall);
      int guard;
      for (int k = 0; k < n; k++) begin
         if (stall) begin
            repeat ($urandom_range(0, 2)) begin
               b_valid = 1'b0; b_data = $urandom; @(negedge aclk);
            end
         end
         b_valid = 1'b1;
         b_data  = jb[k];
         guard   = 0;
         while (!b_ready && guard < 2000) begin @(negedge aclk); guard++; end
         if (!b_ready) begin
            check("b_ready_timeout", {31'd0, b_ready}, 32'd1);
            b_valid = 1'b0;
            return;
         end
         @(negedge aclk);
      end
      b_valid = 1'b0;
      b_data  = $urandom;
   endtask

   task automatic send_a(input int n, input bit stall);
      int guard;
      for (int k = 0; k < n; k++) begin
         if (stall) begin
            repeat ($urandom_range(0, 2)) begin
               a_valid = 1'b0; a_data = $urandom; @(negedge aclk);
            end
         end
         a_valid = 1'b1;
         a_data  = ja[k];
         guard   = 0;
         while (!a_ready && guard < 2000) begin @(negedge aclk); guard++; end
         if (!a_ready) begin
            check("a_ready_timeout", {31'd0, a_ready}, 32'd1);
            a_valid = 1'b0;
            return;
         end
         @(negedge aclk);
      end
      a_valid = 1'b0;
      a_data  = $urandom;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp_lit);
      int guard;
      guard = 0;
      while (!result_valid && guard < 2000) begin @(negedge aclk); guard++; end
      check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
      if (result_valid) check({tag, "_result"}, result, exp_lit);
   endtask

   // Start pulse, streams, result, then confirm a single one-cycle pulse.
   task automatic run_job(input string tag, input int n, input bit stall,
                          input logic [31:0] exp_lit);
      int rv0;
      set_model(n);
      rv0   = n_rv_tot;
      start = 1'b1;
      len   = (L+1)'(n);
      @(negedge aclk);
      start = 1'b0;
      fork
         send_b(n, stall);
         send_a(n, stall);
      join
      wait_result(tag, exp_lit);
      @(negedge aclk);
      check({tag, "_pulse_width"}, {31'd0, result_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_pulses"}, 32'(n_rv_tot - rv0), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {26'd0, b_ready, a_ready, pe_we, pe_valid, result_valid, busy}, 32'd0);
      check({tag, "_pe_ain"}, pe_ain, 32'd0);
      check({tag, "_pe_din"}, pe_din, 32'd0);
      check({tag, "_pe_cin"}, pe_cin, 32'd0);
      check({tag, "_pe_addr"}, 32'(pe_addr), 32'd0);
      check({tag, "_result"}, result, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int rv0, we0, pv0;
      n_vec = 0; n_err = 0; n_we_tot = 0; n_valid_tot = 0; n_rv_tot = 0;
      aresetn = 1'b1; start = 1'b0; len = '0;
      b_valid = 1'b0; a_valid = 1'b0; b_data = '0; a_data = '0;
      set_model(0);
      #1 aresetn = 1'b0;
      @(negedge aclk);
      check_zero("reset");
`ifdef PE_CTRL_CYCCNT_EN
      check("reset_cyc_cnt", cyc_cnt, 32'd0);
`endif
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // Two-element dot product: 2.0*1.0 + 3.0*1.0 = 5.0
      jb[0] = 32'h200; jb[1] = 32'h300; ja[0] = 32'h100; ja[1] = 32'h100;
      run_job("dot2", 2, 1'b0, 32'h500);

      // len=0: result 0 two cycles after start, no PE activity
      set_model(0);
      we0 = n_we_tot; pv0 = n_valid_tot;
      start = 1'b1; len = '0;
      @(negedge aclk);
      start = 1'b0;
      check("len0_rv_early", {31'd0, result_valid}, 32'd0);
      check("len0_busy", {31'd0, busy}, 32'd1);
      @(negedge aclk);
      check("len0_rv", {31'd0, result_valid}, 32'd1);
      check("len0_result", result, 32'd0);
      check("len0_no_we", 32'(n_we_tot - we0), 32'd0);
      check("len0_no_valid", 32'(n_valid_tot - pv0), 32'd0);
`ifdef PE_CTRL_CYCCNT_EN
      check("len0_cyc_cnt", cyc_cnt, 32'd1);
`endif
      @(negedge aclk);

      // Randomly stalled streams: 3 * (1.0*0.5) = 1.5
      for (int k = 0; k < 3; k++) begin jb[k] = 32'h100; ja[k] = 32'h80; end
      pv0 = n_valid_tot;
      run_job("stall3", 3, 1'b1, 32'h180);
      check("stall3_pe_valid_pulses", 32'(n_valid_tot - pv0), 32'd3);

      // Signed operands: -2.0 + 2.5 + 1.0 + 1.0 = 2.5
      jb[0] = 32'hFFFF_FF00; jb[1] = 32'h280; jb[2] = 32'h40;  jb[3] = 32'h1000;
      ja[0] = 32'h200;       ja[1] = 32'h100; ja[2] = 32'h400; ja[3] = 32'h10;
      run_job("signed4", 4, 1'b1, 32'h280);

      // Full-depth job (address wrap) with a stray start mid-job
      for (int k = 0; k < DEPTH; k++) begin jb[k] = 32'(k) << 8; ja[k] = 32'h100; end
      set_model(DEPTH);
      rv0   = n_rv_tot;
      start = 1'b1; len = (L+1)'(DEPTH);
      @(negedge aclk);
      start = 1'b0;
      fork
         send_b(DEPTH, 1'b0);
         send_a(DEPTH, 1'b0);
         begin
            repeat (20) @(negedge aclk);
            start = 1'b1; len = (L+1)'(5);
            @(negedge aclk);
            start = 1'b0; len = (L+1)'(DEPTH);
         end
      join
      wait_result("full64", 32'h7_E000);
      @(negedge aclk);
      check("full64_pulses", 32'(n_rv_tot - rv0), 32'd1);
      check("full64_idle", {31'd0, busy}, 32'd1 ^ 32'd1);

      // Reset during WAIT abandons the job
      jb[0] = 32'h100; jb[1] = 32'h100; ja[0] = 32'h100; ja[1] = 32'h100;
      set_model(2);
      rv0   = n_rv_tot;
      start = 1'b1; len = (L+1)'(2);
      @(negedge aclk);
      start = 1'b0;
      fork
         send_b(2, 1'b0);
         send_a(1, 1'b0);
      join
      check("midrst_issued", {31'd0, pe_valid}, 32'd1);
      #2 aresetn = 1'b0;
      #1 check_zero("midrst");
`ifdef PE_CTRL_CYCCNT_EN
      check("midrst_cyc_cnt", cyc_cnt, 32'd0);
`endif
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);
      check("midrst_no_rv", 32'(n_rv_tot - rv0), 32'd0);
      check("midrst_idle", {31'd0, busy}, 32'd0);

      // Job after reset: 1.0*3.0
      jb[0] = 32'h100; ja[0] = 32'h300;
      run_job("after_rst", 1, 1'b0, 32'h300);
`ifdef PE_CTRL_CYCCNT_EN
      check("cyc_cnt_len1", cyc_cnt, 32'(LAT + 5));
`endif

      // start held high: one job, then a second from IDLE
      jb[0] = 32'h100; jb[1] = 32'h200; ja[0] = 32'h100; ja[1] = 32'h100;
      set_model(2);
      rv0   = n_rv_tot;
      start = 1'b1; len = (L+1)'(2);
      @(negedge aclk);
      fork
         send_b(2, 1'b0);
         send_a(2, 1'b0);
      join
      wait_result("hold1", 32'h300);
      @(negedge aclk);
      start = 1'b0;
      check("hold_restart_busy", {31'd0, busy}, 32'd1);
      check("hold1_pulses", 32'(n_rv_tot - rv0), 32'd1);
      fork
         send_b(2, 1'b0);
         send_a(2, 1'b0);
      join
      wait_result("hold2", 32'h300);
      @(negedge aclk);
      check("hold2_pulses", 32'(n_rv_tot - rv0), 32'd2);
      check("hold2_idle", {31'd0, busy}, 32'd0);

      repeat (2) @(negedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
